// File: rtl/freq_div_pkg.sv
// ----------------------------------------------------------------------------
// freq_div_pkg : shared defaults and helpers for the programmable divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package freq_div_pkg;

  localparam int DIV_C1_DEF = 3;
  localparam int DIV_C0_DEF = 2;
  localparam int CW_DEF     = 8;

  // Number of high cycles per period; odd ratios get the extra cycle high.
  function automatic int high_len(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/main_if.sv
// ----------------------------------------------------------------------------
// main_if : ratio-select input and divided-clock output of the divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface main_if;

  logic C1;
  logic clockout;

  modport master (output C1, input clockout);
  modport slave  (input C1, output clockout);

endinterface

`default_nettype wire

// File: rtl/div_phase_counter.sv
// ----------------------------------------------------------------------------
// div_phase_counter : modulo-N phase counter, ratio reloaded at wrap/reset
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_phase_counter
  import freq_div_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] ratio_i,
  output logic [CW-1:0] phase_d_o,
  output logic [CW-1:0] ratio_d_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] ratio_q;
  logic [CW-1:0] ratio_d;
  logic          wrap_w;

  // ">=" keeps the counter bounded even if it ever sits above N-1.
  always_comb begin
    wrap_w  = (cnt_q >= (ratio_q - CW'(1)));
    cnt_d   = cnt_q + CW'(1);
    ratio_d = ratio_q;
    if (wrap_w) begin
      cnt_d   = '0;
      ratio_d = ratio_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ratio_q <= ratio_i;
      cnt_q   <= ratio_i - CW'(1);
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_d_o = cnt_d;
  assign ratio_d_o = ratio_d;
  assign wrap_o    = wrap_w;

endmodule

`default_nettype wire

// File: rtl/main.sv
// ----------------------------------------------------------------------------
// main : programmable synchronous clock divider, ratio selected by C1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module main
  import freq_div_pkg::*;
#(
  parameter int DIV_C1 = DIV_C1_DEF,
  parameter int DIV_C0 = DIV_C0_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic   clk,
  input  logic   rst,
  main_if.slave  bus
);

  localparam logic [CW-1:0] C_DIV_C1 = CW'(DIV_C1);
  localparam logic [CW-1:0] C_DIV_C0 = CW'(DIV_C0);

  logic [CW-1:0] ratio_sel_w;
  logic [CW-1:0] phase_d;
  logic [CW-1:0] ratio_d;
  logic [CW-1:0] high_w;
  logic          wrap_w;
  logic          clockout_d;
  logic          clockout_q;

  assign ratio_sel_w = bus.C1 ? C_DIV_C1 : C_DIV_C0;

  div_phase_counter #(
    .CW (CW)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .ratio_i   (ratio_sel_w),
    .phase_d_o (phase_d),
    .ratio_d_o (ratio_d),
    .wrap_o    (wrap_w)
  );

  // Compare against the phase/ratio the counter is about to take so the
  // registered output lines up with the counter value after the same edge.
  always_comb begin
    high_w     = CW'(high_len(int'(ratio_d)));
    clockout_d = wrap_w ? 1'b1 : (phase_d < high_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clockout_q <= 1'b0;
    end else begin
      clockout_q <= clockout_d;
    end
  end

  assign bus.clockout = clockout_q;

endmodule

`default_nettype wire

// File: tb/tb_main.sv
// ----------------------------------------------------------------------------
// tb_main : scoreboard bench for main, default ratios and a 5/4 build
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_main;

  logic clk;
  logic rst;
  logic c1;

  int n_checks;
  int n_errors;

  main_if u_if_a ();
  main_if u_if_b ();

  assign u_if_a.C1 = c1;
  assign u_if_b.C1 = c1;

  main u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (u_if_a)
  );

  main #(
    .DIV_C1 (5),
    .DIV_C0 (4),
    .CW     (8)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (u_if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: active ratio and phase after the last edge.
  int ma_n, ma_p, mb_n, mb_p;
  logic q_a[$];
  logic q_b[$];

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s : got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int d1, input int d0, inout int n, inout int p,
                            output logic exp);
    if (rst) begin
      n   = c1 ? d1 : d0;
      p   = n - 1;
      exp = 1'b0;
    end else begin
      if (p == n - 1) begin
        n = c1 ? d1 : d0;
        p = 0;
      end else begin
        p = p + 1;
      end
      exp = (p < (n + 1) / 2);
    end
  endtask

  // One clock: drive inputs, push expectations, then compare after the edge.
  task automatic step(input logic r, input logic c, input string tag);
    logic ea, eb, pa, pb;
    @(negedge clk);
    rst = r;
    c1  = c;
    model_edge(3, 2, ma_n, ma_p, ea);
    model_edge(5, 4, mb_n, mb_p, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    pa = q_a.pop_front();
    pb = q_b.pop_front();
    check_eq({tag, "_a"}, u_if_a.clockout, pa);
    check_eq({tag, "_b"}, u_if_b.clockout, pb);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    c1   = 1'b1;
    ma_n = 3; ma_p = 2;
    mb_n = 5; mb_p = 4;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset_hold");

    // Free run at N=3, also held against the literal 1,1,0 pattern.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, "run_n3");
      check_eq("pat_110", u_if_a.clockout, (i % 3) != 2);
    end

    // Reset during the second high cycle.
    step(1'b0, 1'b1, "pre_rst");
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, "mid_rst");
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, "post_rst");
      check_eq("restart_110", u_if_a.clockout, (i % 3) != 2);
    end

    // Drop C1 mid-period; the current 3-cycle period must finish intact.
    step(1'b0, 1'b1, "sw_pre");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "sw_n2");

    for (int i = 0; i < 20; i++) step(1'b0, (i % 2) == 0, "toggle");

    // Realign both builds with a reset, then sweep each ratio.
    step(1'b1, 1'b1, "sweep_rst");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, "sweep_c1");
      check_eq("pat_11100", u_if_b.clockout, (i % 5) < 3);
    end
    step(1'b1, 1'b0, "sweep_rst0");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, "sweep_c0");
      check_eq("pat_1100", u_if_b.clockout, (i % 4) < 2);
      check_eq("pat_10", u_if_a.clockout, (i % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
